// File: rtl/fract_addsub_lzc_if.sv
// Handshake and data bundle between pre_norm, fract_addsub_lzc and post_norm.
// master = upstream/downstream environment side, slave = the add/sub stage.
interface fract_addsub_lzc_if #(
  parameter int FW  = 27,
  parameter int EW  = 8,
  parameter int LZW = 5
) ();

  logic           in_valid;
  logic           in_ready;
  logic [FW-1:0]  fracta;
  logic [FW-1:0]  fractb;
  logic [EW-1:0]  exp_dn;
  logic           sign;
  logic           zero_sign;
  logic           fasu_op;

  logic           out_valid;
  logic           out_ready;
  logic [FW-1:0]  sum;
  logic           co;
  logic [LZW-1:0] lzc;
  logic           res_zero;
  logic [EW-1:0]  exp_out;
  logic           sign_out;

  modport master (
    output in_valid, fracta, fractb, exp_dn, sign, zero_sign, fasu_op, out_ready,
    input  in_ready, out_valid, sum, co, lzc, res_zero, exp_out, sign_out
  );

  modport slave (
    input  in_valid, fracta, fractb, exp_dn, sign, zero_sign, fasu_op, out_ready,
    output in_ready, out_valid, sum, co, lzc, res_zero, exp_out, sign_out
  );

endinterface

// File: rtl/fract_addsub_lzc.sv
// FPU add/sub fraction stage: 27-bit magnitude add/subtract followed by a
// leading-zero count, as a two-stage valid/ready pipeline feeding post_norm.
module fract_addsub_lzc #(
  parameter int FW  = 27,
  parameter int EW  = 8,
  parameter int LZW = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fract_addsub_lzc_if.slave    bus,
  input  logic                 clr_err,
  output logic                 borrow_err
);

  // Stage 1 state: raw (FW+1)-bit result plus side-band fields.
  logic          s1_valid;
  logic [FW:0]   s1_res;
  logic [EW-1:0] s1_exp;
  logic          s1_sign;
  logic          s1_zsign;

  logic          s2_valid;

  logic          s2_free;
  logic          s1_adv;
  logic          accept;

  logic [FW:0]   ext_a;
  logic [FW:0]   ext_b;
  logic [FW:0]   add_res;
  logic          borrow;

  logic [LZW-1:0] lz_cnt;
  logic           lz_found;
  logic           s1_zero;

  // Ready propagates backwards combinationally so a draining S2 frees S1 in
  // the same cycle; nothing combinational runs from in_valid to out_valid.
  assign s2_free      = !s2_valid || bus.out_ready;
  assign s1_adv       = s1_valid && s2_free;
  assign bus.in_ready = !s1_valid || s1_adv;
  assign accept       = bus.in_valid && bus.in_ready;
  assign bus.out_valid = s2_valid;

  // Subtract is done in FW+1 bits so the MSB doubles as the borrow flag.
  always_comb begin
    ext_a   = {1'b0, bus.fracta};
    ext_b   = {1'b0, bus.fractb};
    add_res = bus.fasu_op ? (ext_a + ext_b) : (ext_a - ext_b);
    borrow  = !bus.fasu_op && (bus.fracta < bus.fractb);
  end

  // NOTE: every variable assigned in always_comb gets a default before any
  // conditional update, otherwise synthesis infers a latch.
  always_comb begin
    lz_found = 1'b0;
    lz_cnt   = LZW'(FW + 1);
    for (int i = FW; i >= 0; i--) begin
      if (!lz_found && s1_res[i]) begin
        lz_cnt   = LZW'(FW - i);
        lz_found = 1'b1;
      end
    end
    s1_zero = (s1_res == '0);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_res   <= '0;
      s1_exp   <= '0;
      s1_sign  <= 1'b0;
      s1_zsign <= 1'b0;
    end else begin
      if (accept) begin
        s1_valid <= 1'b1;
        s1_res   <= add_res;
        s1_exp   <= bus.exp_dn;
        s1_sign  <= bus.sign;
        s1_zsign <= bus.zero_sign;
      end else if (s1_adv) begin
        s1_valid <= 1'b0;
      end
    end
  end

  // NOTE: S2 data registers are reset as well because they drive the block
  // outputs directly and must read zero straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid     <= 1'b0;
      bus.sum      <= '0;
      bus.co       <= 1'b0;
      bus.lzc      <= '0;
      bus.res_zero <= 1'b0;
      bus.exp_out  <= '0;
      bus.sign_out <= 1'b0;
    end else begin
      if (s1_adv) begin
        s2_valid     <= 1'b1;
        bus.sum      <= s1_res[FW-1:0];
        bus.co       <= s1_res[FW];
        bus.lzc      <= lz_cnt;
        bus.res_zero <= s1_zero;
        bus.exp_out  <= s1_exp;
        bus.sign_out <= s1_zero ? s1_zsign : s1_sign;
      end else if (bus.out_ready) begin
        s2_valid <= 1'b0;
      end
    end
  end

  // A fresh borrow takes priority over a clear landing in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      borrow_err <= 1'b0;
    end else if (accept && borrow) begin
      borrow_err <= 1'b1;
    end else if (clr_err) begin
      borrow_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fract_addsub_lzc.sv
// Directed self-checking bench for fract_addsub_lzc: arithmetic corner cases,
// sticky borrow flag, backpressure ordering and asynchronous reset mid-stall.
module tb_fract_addsub_lzc;

  logic clk = 1'b0;
  logic rst_n;
  logic clr_err;
  logic borrow_err;

  int checks = 0;
  int errors = 0;

  fract_addsub_lzc_if bus ();

  fract_addsub_lzc dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus.slave),
    .clr_err    (clr_err),
    .borrow_err (borrow_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one operand set for exactly one cycle (in_ready assumed high).
  task automatic issue(input logic [26:0] a, input logic [26:0] b, input logic op,
                       input logic [7:0] e, input logic s, input logic zs);
    bus.fracta    = a;
    bus.fractb    = b;
    bus.fasu_op   = op;
    bus.exp_dn    = e;
    bus.sign      = s;
    bus.zero_sign = zs;
    bus.in_valid  = 1'b1;
    step();
    bus.in_valid  = 1'b0;
  endtask

  logic [26:0] held_sum;
  logic        held_v;
  int          n_in;
  int          n_out;

  initial begin
    rst_n         = 1'b0;
    clr_err       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.fracta    = '0;
    bus.fractb    = '0;
    bus.exp_dn    = '0;
    bus.sign      = 1'b0;
    bus.zero_sign = 1'b0;
    bus.fasu_op   = 1'b1;

    #12;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_borrow_err", 64'(borrow_err), 64'd0);
    check("rst_sum", 64'(bus.sum), 64'd0);
    check("rst_lzc", 64'(bus.lzc), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("idle_in_ready", 64'(bus.in_ready), 64'd1);

    // Add, no carry.
    issue(27'h4000000, 27'h2000000, 1'b1, 8'h7F, 1'b0, 1'b0);
    check("add_latency_1", 64'(bus.out_valid), 64'd0);
    step();
    check("add_out_valid", 64'(bus.out_valid), 64'd1);
    check("add_sum", 64'(bus.sum), 64'h6000000);
    check("add_co", 64'(bus.co), 64'd0);
    check("add_lzc", 64'(bus.lzc), 64'd1);
    check("add_res_zero", 64'(bus.res_zero), 64'd0);
    check("add_exp_out", 64'(bus.exp_out), 64'h7F);
    check("add_sign_out", 64'(bus.sign_out), 64'd0);
    step();
    check("add_drained", 64'(bus.out_valid), 64'd0);

    // Add with carry out.
    issue(27'h4000000, 27'h4000000, 1'b1, 8'h80, 1'b1, 1'b0);
    step();
    check("carry_sum", 64'(bus.sum), 64'h0);
    check("carry_co", 64'(bus.co), 64'd1);
    check("carry_lzc", 64'(bus.lzc), 64'd0);
    check("carry_res_zero", 64'(bus.res_zero), 64'd0);
    check("carry_sign_out", 64'(bus.sign_out), 64'd1);
    step();

    // Exact cancellation: zero result takes zero_sign.
    issue(27'h5A5A5A0, 27'h5A5A5A0, 1'b0, 8'h10, 1'b1, 1'b0);
    step();
    check("cancel_sum", 64'(bus.sum), 64'h0);
    check("cancel_co", 64'(bus.co), 64'd0);
    check("cancel_lzc", 64'(bus.lzc), 64'd28);
    check("cancel_res_zero", 64'(bus.res_zero), 64'd1);
    check("cancel_sign_out", 64'(bus.sign_out), 64'd0);
    check("cancel_borrow_err", 64'(borrow_err), 64'd0);
    step();

    // Illegal borrow and sticky flag.
    issue(27'h1000000, 27'h2000000, 1'b0, 8'h20, 1'b0, 1'b0);
    check("borrow_err_set", 64'(borrow_err), 64'd1);
    step();
    check("borrow_co", 64'(bus.co), 64'd1);
    check("borrow_sum", 64'(bus.sum), 64'h7000000);
    check("borrow_lzc", 64'(bus.lzc), 64'd0);
    step();
    check("borrow_err_sticky", 64'(borrow_err), 64'd1);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    check("borrow_err_clr", 64'(borrow_err), 64'd0);

    // New borrow and clear in the same cycle: set wins.
    clr_err = 1'b1;
    issue(27'h0000001, 27'h0000002, 1'b0, 8'h21, 1'b0, 1'b0);
    clr_err = 1'b0;
    check("borrow_set_wins", 64'(borrow_err), 64'd1);
    step();
    check("borrow_small_sum", 64'(bus.sum), 64'h7FFFFFF);
    check("borrow_small_lzc", 64'(bus.lzc), 64'd0);
    step();
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    check("borrow_err_clr2", 64'(borrow_err), 64'd0);

    // Backpressure: 4 back-to-back ops, out_ready low for cycles 3..6.
    n_in    = 0;
    n_out   = 0;
    held_v  = 1'b0;
    held_sum = '0;
    bus.fasu_op   = 1'b1;
    bus.sign      = 1'b0;
    bus.zero_sign = 1'b0;
    for (int c = 0; c < 30; c++) begin
      bus.out_ready = !(c >= 3 && c <= 6);
      bus.in_valid  = (n_in < 4);
      bus.fracta    = 27'h1000000 + 27'(n_in);
      bus.fractb    = 27'(n_in);
      bus.exp_dn    = 8'(n_in);
      #1;
      if (c == 3) check("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
      if (held_v) check("bp_hold_sum", 64'(bus.sum), 64'(held_sum));
      if (bus.out_valid && bus.out_ready) begin
        check("bp_sum", 64'(bus.sum), 64'(27'h1000000 + 27'(2 * n_out)));
        check("bp_exp_out", 64'(bus.exp_out), 64'(n_out));
        n_out++;
      end
      held_v   = bus.out_valid && !bus.out_ready;
      held_sum = bus.sum;
      if (bus.in_valid && bus.in_ready) n_in++;
      step();
    end
    bus.in_valid = 1'b0;
    check("bp_count", 64'(n_out), 64'd4);

    // Reset mid-stall with two ops in flight (first one a borrow).
    bus.out_ready = 1'b0;
    issue(27'h1000000, 27'h2000000, 1'b0, 8'h30, 1'b0, 1'b0);
    issue(27'h0100000, 27'h0000001, 1'b1, 8'h31, 1'b0, 1'b0);
    check("rst_pre_out_valid", 64'(bus.out_valid), 64'd1);
    check("rst_pre_borrow_err", 64'(borrow_err), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_mid_borrow_err", 64'(borrow_err), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    step();
    check("rst_rel_in_ready", 64'(bus.in_ready), 64'd1);
    for (int k = 0; k < 4; k++) begin
      check("rst_no_stale", 64'(bus.out_valid), 64'd0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
